// File: rtl/dec_return_addr_stack.sv
// Return-address stack for the decode stage.
// CALL pushes PC+4. RET pops the predicted return target.
// CALL together with RET swaps the top entry (coroutine swap).
// FLUSH empties the stack.
// All outputs are registered and reflect the previous cycle's event.
// Optional feature: define RAS_CHECKPOINT_EN to add the CKPT_SAVE and
// CKPT_RESTORE ports, which snapshot and restore the tos pointer and count.
module dec_return_addr_stack #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PC,
  input  logic              CALL,
  input  logic              RET,
  input  logic              FLUSH,
`ifdef RAS_CHECKPOINT_EN
  input  logic              CKPT_SAVE,
  input  logic              CKPT_RESTORE,
`endif
  output logic              RET_valid,
  output logic [ADDR_W-1:0] RET_target_addr,
  output logic              OVERFLOW
);

  localparam int unsigned    PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_FLUSH,
    OP_RESTORE,
    OP_PUSH,
    OP_POP,
    OP_SWAP
  } op_e;

  logic [ADDR_W-1:0] stack [DEPTH];
  logic [PTR_W-1:0]  tos, tos_nxt;
  logic [PTR_W:0]    count, count_nxt;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] link;
  logic              valid_nxt;
  logic [ADDR_W-1:0] target_nxt;
  logic              ovf_nxt;
  op_e               op;

`ifdef RAS_CHECKPOINT_EN
  logic [PTR_W-1:0]  ckpt_tos;
  logic [PTR_W:0]    ckpt_count;
`endif

  assign link = PC + ADDR_W'(4);

  // Resolve the operation for this cycle by priority.
  always_comb begin
    op = OP_NONE;
    if (FLUSH)
      op = OP_FLUSH;
`ifdef RAS_CHECKPOINT_EN
    else if (CKPT_RESTORE)
      op = OP_RESTORE;
`endif
    else if (CALL && RET)
      op = OP_SWAP;
    else if (CALL)
      op = OP_PUSH;
    else if (RET)
      op = OP_POP;
  end

  // Compute the next pointer, count, entry write and output values.
  always_comb begin
    tos_nxt    = tos;
    count_nxt  = count;
    wr_en      = 1'b0;
    wr_idx     = tos;
    valid_nxt  = 1'b0;
    target_nxt = RET_target_addr;
    ovf_nxt    = 1'b0;
    case (op)
      OP_FLUSH: begin
        tos_nxt    = '0;
        count_nxt  = '0;
        target_nxt = '0;
      end
`ifdef RAS_CHECKPOINT_EN
      OP_RESTORE: begin
        tos_nxt   = ckpt_tos;
        count_nxt = ckpt_count;
      end
`endif
      OP_PUSH: begin
        // When full, the slot after tos holds the oldest entry and is overwritten.
        tos_nxt = tos + 1'b1;
        wr_en   = 1'b1;
        wr_idx  = tos + 1'b1;
        if (count == CNT_MAX)
          ovf_nxt = 1'b1;
        else
          count_nxt = count + 1'b1;
      end
      OP_POP: begin
        if (count != '0) begin
          valid_nxt  = 1'b1;
          target_nxt = stack[tos];
          tos_nxt    = tos - 1'b1;
          count_nxt  = count - 1'b1;
        end else begin
          target_nxt = '0;
        end
      end
      OP_SWAP: begin
        // The old top is read before it is replaced, and tos does not move.
        wr_en  = 1'b1;
        wr_idx = tos;
        if (count != '0) begin
          valid_nxt  = 1'b1;
          target_nxt = stack[tos];
        end else begin
          count_nxt = CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  // Pointer, count, output and checkpoint registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tos             <= '0;
      count           <= '0;
      RET_valid       <= 1'b0;
      RET_target_addr <= '0;
      OVERFLOW        <= 1'b0;
`ifdef RAS_CHECKPOINT_EN
      ckpt_tos        <= '0;
      ckpt_count      <= '0;
`endif
    end else begin
      tos             <= tos_nxt;
      count           <= count_nxt;
      RET_valid       <= valid_nxt;
      RET_target_addr <= target_nxt;
      OVERFLOW        <= ovf_nxt;
`ifdef RAS_CHECKPOINT_EN
      if (CKPT_SAVE) begin
        ckpt_tos   <= tos_nxt;
        ckpt_count <= count_nxt;
      end
`endif
    end
  end

  // Entry storage. Reset does not clear the entries.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en)
      stack[wr_idx] <= link;
  end

endmodule

// File: tb/tb_dec_return_addr_stack.sv
// Scoreboard bench for dec_return_addr_stack (DEPTH=4, ADDR_W=40).
// The reference model keeps the live entries in a bounded queue.
module tb_dec_return_addr_stack;

  localparam int unsigned AW = 40;
  localparam int unsigned DP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          ret_valid;
  logic [AW-1:0] ret_target;
  logic          overflow;

  typedef struct {
    logic          valid;
    logic [AW-1:0] target;
    logic          ovf;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] mq[$];
  logic [AW-1:0] m_tgt = '0;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  dec_return_addr_stack #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .CLK(clk),
    .RST(rst),
    .PC(pc),
    .CALL(call),
    .RET(ret),
    .FLUSH(flush),
`ifdef RAS_CHECKPOINT_EN
    .CKPT_SAVE(1'b0),
    .CKPT_RESTORE(1'b0),
`endif
    .RET_valid(ret_valid),
    .RET_target_addr(ret_target),
    .OVERFLOW(overflow)
  );

  // Drive one cycle of stimulus and queue the response the model predicts.
  task automatic step(input logic r, input logic c, input logic t, input logic f,
                      input logic [AW-1:0] p);
    exp_t          e;
    logic [AW-1:0] lnk;
    @(negedge clk);
    rst = r; call = c; ret = t; flush = f; pc = p;
    lnk = p + 40'd4;
    e.valid = 1'b0;
    e.ovf = 1'b0;
    if (r || f) begin
      mq.delete();
      m_tgt = '0;
    end else if (c && t) begin
      if (mq.size() > 0) begin
        m_tgt = mq[mq.size()-1];
        e.valid = 1'b1;
        mq[mq.size()-1] = lnk;
      end else begin
        mq.push_back(lnk);
      end
    end else if (c) begin
      mq.push_back(lnk);
      if (mq.size() > DP) begin
        void'(mq.pop_front());
        e.ovf = 1'b1;
      end
    end else if (t) begin
      if (mq.size() > 0) begin
        m_tgt = mq.pop_back();
        e.valid = 1'b1;
      end else begin
        m_tgt = '0;
      end
    end
    e.target = m_tgt;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every registered output against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (ret_valid !== e.valid) begin
          failures++;
          $display("FAIL ret_valid t=%0t got=%0b exp=%0b", $time, ret_valid, e.valid);
        end
        checks++;
        if (ret_target !== e.target) begin
          failures++;
          $display("FAIL ret_target t=%0t got=%h exp=%h", $time, ret_target, e.target);
        end
        checks++;
        if (overflow !== e.ovf) begin
          failures++;
          $display("FAIL overflow t=%0t got=%0b exp=%0b", $time, overflow, e.ovf);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] rpc;
    // Reset, then the single call/return pair.
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, 40'h1000);
    step(0, 0, 1, 0, '0);
    // Three nested calls unwound in order.
    step(0, 1, 0, 0, 40'h100);
    step(0, 1, 0, 0, 40'h200);
    step(0, 1, 0, 0, 40'h300);
    repeat (3) step(0, 0, 1, 0, '0);
    // Underflow after reset; a flush empties the stack.
    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 0, '0);
    step(0, 1, 0, 0, 40'h700);
    step(0, 0, 0, 1, '0);
    step(0, 0, 1, 0, '0);
    // Five calls into four entries overwrite the oldest one.
    for (int i = 1; i <= 5; i++) step(0, 1, 0, 0, AW'(i * 16));
    repeat (5) step(0, 0, 1, 0, '0);
    // Coroutine swap.
    step(0, 1, 0, 0, 40'hA0);
    step(0, 1, 1, 0, 40'hB0);
    step(0, 0, 1, 0, '0);
    step(0, 0, 1, 0, '0);
    // Reset in the middle of a sequence with three entries live.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, AW'(32'h5000 + i * 4));
    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 0, '0);
    // The link address wraps to zero.
    step(0, 1, 0, 0, 40'hFF_FFFF_FFFC);
    step(0, 0, 1, 0, '0);
    // Randomized mix of events, including addresses near the top of the range.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0)
        rpc = 40'hFF_FFFF_FFF0 + AW'($urandom_range(0, 15));
      else
        rpc = {$urandom, $urandom};
      step(($urandom_range(0, 99) < 2), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 99) < 5), rpc);
    end
    step(0, 0, 0, 0, '0);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
